// File: rtl/wave_synth_if.sv
// wave_synth_if: control and sample bus of the wave_synth DDS generator.
// The master side drives frequency/mode controls and consumes samples; the
// slave side is the generator itself. The amp signal exists only when
// WAVE_SYNTH_AMP_EN is defined.
interface wave_synth_if #(
  parameter int OUT_W   = 8,
  parameter int PHASE_W = 16
);
  logic               en;
  logic [PHASE_W-1:0] tw_in;
  logic               tw_load;
  logic [1:0]         mode;
`ifdef WAVE_SYNTH_AMP_EN
  logic [OUT_W-1:0]   amp;
`endif
  logic [OUT_W-1:0]   wave;
  logic               wave_valid;
  logic               phase_sync;

`ifdef WAVE_SYNTH_AMP_EN
  modport master (output en, tw_in, tw_load, mode, amp,
                  input  wave, wave_valid, phase_sync);
  modport slave  (input  en, tw_in, tw_load, mode, amp,
                  output wave, wave_valid, phase_sync);
`else
  modport master (output en, tw_in, tw_load, mode,
                  input  wave, wave_valid, phase_sync);
  modport slave  (input  en, tw_in, tw_load, mode,
                  output wave, wave_valid, phase_sync);
`endif
endinterface

// File: rtl/wave_synth.sv
// wave_synth: direct-digital-synthesis waveform generator.
// Phase accumulator -> shape register (sine/triangle/saw/square) -> output
// register; latency 2 enabled cycles. Output period = 2^PHASE_W / tw.
// Optional macro WAVE_SYNTH_AMP_EN adds the amp input and one scaling stage
// (latency 3). Constraints: PHASE_W >= LUT_AW+2 and PHASE_W >= OUT_W+1.
module wave_synth #(
  parameter int                 OUT_W    = 8,
  parameter int                 PHASE_W  = 16,
  parameter int                 LUT_AW   = 8,
  parameter logic [PHASE_W-1:0] TW_RESET = '0
) (
  input  logic          s_clk,
  input  logic          reset,
  wave_synth_if.slave   bus
);

  localparam int               LUT_N = 2 ** LUT_AW;
  localparam int               M     = 2 ** (OUT_W - 1) - 1;
  localparam logic [OUT_W-1:0] MID   = OUT_W'(M);

  // Quarter-wave entry k: round(M * sin(pi/2 * (k+0.5) / LUT_N)), evaluated
  // at elaboration with a Taylor series so no math library is needed.
  function automatic int sine_entry(input int k);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_N);
    term = x;
    sum  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(real'(M) * sum + 0.5);
  endfunction

  // NOTE: the quarter-wave table is a constant ROM built from elaboration-time
  // parameters; it holds no state, so it has no reset and no write port.
  logic [OUT_W-2:0] sin_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam int LV = sine_entry(k);
    assign sin_lut[k] = (OUT_W-1)'(LV);
  end

  // ---------------------------------------------------------------- stage 0
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] tw;
  logic               acc_wrap;
  logic [PHASE_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, tw};

  // Tuning word register: loads whenever strobed, regardless of en.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline ordering cannot race.
  always_ff @(posedge s_clk) begin
    if (reset)            tw <= TW_RESET;
    else if (bus.tw_load) tw <= bus.tw_in;
  end

  // Phase accumulator; the carry-out tags the first phase of a new period.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      acc      <= '0;
      acc_wrap <= 1'b0;
    end else if (bus.en) begin
      acc      <= acc_sum[PHASE_W-1:0];
      acc_wrap <= acc_sum[PHASE_W];
    end
  end

  // ---------------------------------------------------------------- shaping
  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW-1:0] lut_addr;
  logic [OUT_W-2:0]  lut_val;
  logic [OUT_W-1:0]  tri_t;
  logic [OUT_W-1:0]  raw_next;

  assign quad     = acc[PHASE_W-1 -: 2];
  assign idx      = acc[PHASE_W-3 -: LUT_AW];
  // Odd quadrants read the table mirrored: 2^LUT_AW-1-i is just ~i.
  assign lut_addr = quad[0] ? ~idx : idx;
  assign lut_val  = sin_lut[lut_addr];
  assign tri_t    = acc[PHASE_W-2 -: OUT_W];

  // Waveform select from the current phase.
  // NOTE: raw_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    raw_next = MID;
    case (bus.mode)
      2'd0: raw_next = quad[1] ? (MID - {1'b0, lut_val}) : (MID + {1'b0, lut_val});
      2'd1: raw_next = acc[PHASE_W-1] ? ~tri_t : tri_t;
      2'd2: raw_next = acc[PHASE_W-1 -: OUT_W];
      2'd3: raw_next = acc[PHASE_W-1] ? '0 : '1;
    endcase
  end

  // ---------------------------------------------------------------- stage 1
  logic [OUT_W-1:0] raw_q;
  logic             raw_vld;
  logic             raw_sync;

  // Shape register; the wrap tag travels alongside its sample.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      raw_q    <= MID;
      raw_vld  <= 1'b0;
      raw_sync <= 1'b0;
    end else if (bus.en) begin
      raw_q    <= raw_next;
      raw_vld  <= 1'b1;
      raw_sync <= acc_wrap;
    end
  end

  // ---------------------------------------------------------------- output
  logic [OUT_W-1:0] out_q;
  logic             out_vld;
  logic             out_sync;

`ifdef WAVE_SYNTH_AMP_EN
  localparam logic [OUT_W-1:0] HALF = OUT_W'(2 ** (OUT_W - 1));

  logic signed [OUT_W:0]     s_val;
  logic signed [OUT_W:0]     amp_s;
  logic signed [2*OUT_W+1:0] prod_full;
  logic [OUT_W-1:0]          scaled_q;
  logic                      scaled_vld;
  logic                      scaled_sync;
  logic                      prod_unused;

  assign s_val     = $signed({1'b0, raw_q}) - $signed({1'b0, HALF});
  assign amp_s     = $signed({1'b0, bus.amp});
  assign prod_full = s_val * amp_s;
  // Bits [2*OUT_W-1:OUT_W] are (s*amp) >>> OUT_W; the result always fits
  // OUT_W bits once offset by HALF, so the remaining bits are dropped.
  assign prod_unused = ^{prod_full[2*OUT_W+1:2*OUT_W], prod_full[OUT_W-1:0]};

  // Scaling stage: signed product of the centred sample and amp.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      scaled_q    <= '0;
      scaled_vld  <= 1'b0;
      scaled_sync <= 1'b0;
    end else if (bus.en) begin
      scaled_q    <= prod_full[2*OUT_W-1:OUT_W];
      scaled_vld  <= raw_vld;
      scaled_sync <= raw_sync;
    end
  end

  // Output register: re-centre the scaled sample on mid-scale.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      out_q    <= MID;
      out_vld  <= 1'b0;
      out_sync <= 1'b0;
    end else if (bus.en) begin
      out_q    <= scaled_q + HALF;
      out_vld  <= scaled_vld;
      out_sync <= scaled_sync;
    end
  end
`else
  // Output register: raw sample passes straight through.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      out_q    <= MID;
      out_vld  <= 1'b0;
      out_sync <= 1'b0;
    end else if (bus.en) begin
      out_q    <= raw_q;
      out_vld  <= raw_vld;
      out_sync <= raw_sync;
    end
  end
`endif

  assign bus.wave       = out_q;
  assign bus.wave_valid = out_vld;
  // The sync tag is held through a stall but only shown while advancing.
  assign bus.phase_sync = out_sync & bus.en;

endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: directed self-checking bench for wave_synth in its default
// build (OUT_W=8, PHASE_W=16, LUT_AW=8, no amplitude stage).
module tb_wave_synth;

  localparam int OUT_W   = 8;
  localparam int PHASE_W = 16;
  localparam int LUT_AW  = 8;

  logic s_clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  wave_synth_if #(.OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

  wave_synth #(
    .OUT_W   (OUT_W),
    .PHASE_W (PHASE_W),
    .LUT_AW  (LUT_AW),
    .TW_RESET(16'h0000)
  ) dut (
    .s_clk(s_clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 s_clk = ~s_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are stable 1 time unit after the rising edge.
  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Reset with en low, load tw, select mode, then enable. On return the
  // first valid sample (phase 0) is on the output; each tick gives the next.
  task automatic start_sweep(input logic [1:0] m, input logic [15:0] t);
    bus.en = 1'b0;
    reset  = 1'b1;
    tick();
    reset       = 1'b0;
    bus.tw_in   = t;
    bus.tw_load = 1'b1;
    tick();
    bus.tw_load = 1'b0;
    bus.mode    = m;
    bus.en      = 1'b1;
    tick();
    tick();
  endtask

  logic [7:0] sine_s [256];
  int         sync_cnt;
  int         sync_first;
  int         sync_last;
  int         exp_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset, with a tw_load that must be ignored
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.tw_in   = 16'h1234;
    bus.tw_load = 1'b1;
    bus.mode    = 2'd0;
`ifdef WAVE_SYNTH_AMP_EN
    bus.amp     = 8'hFF;
`endif
    tick(); tick(); tick();
    check("rst_wave", bus.wave, 127);
    check("rst_valid", bus.wave_valid, 0);
    check("rst_sync", bus.phase_sync, 0);
    reset       = 1'b0;
    bus.tw_load = 1'b0;
    tick();
    check("valid_lat1", bus.wave_valid, 0);
    tick();
    check("valid_lat2", bus.wave_valid, 1);
    check("first_wave", bus.wave, 127);
    repeat (5) tick();
    check("tw0_hold_wave", bus.wave, 127);
    check("tw0_hold_valid", bus.wave_valid, 1);

    // ---------------- sine, tw=0x0100: two full periods
    start_sweep(2'd0, 16'h0100);
    sync_cnt   = 0;
    sync_first = -1;
    sync_last  = -1;
    for (int k = 0; k <= 512; k++) begin
      if (k < 256) sine_s[k] = bus.wave;
      if (bus.phase_sync) begin
        sync_cnt++;
        if (sync_first < 0) sync_first = k;
        sync_last = k;
      end
      if (k == 256) check("sine_wrap_wave", bus.wave, 127);
      if (k < 512) tick();
    end
    check("sine_p0000", sine_s[0], 127);
    check("sine_p2000", sine_s[32], 217);
    check("sine_p3F00", sine_s[63], 254);
    check("sine_p4000", sine_s[64], 254);
    check("sine_p8000", sine_s[128], 127);
    check("sine_pBF00", sine_s[191], 0);
    check("sine_sync_cnt", sync_cnt, 2);
    check("sine_sync_first", sync_first, 256);
    check("sine_sync_last", sync_last, 512);
    for (int k = 0; k < 128; k++)
      check($sformatf("sine_sym[%0d]", k), 32'(sine_s[k]) + 32'(sine_s[k+128]), 254);

    // ---------------- square, tw=0x4000, then a 10-cycle stall
    start_sweep(2'd3, 16'h4000);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("sq_wave[%0d]", k), bus.wave, (k % 4 < 2) ? 255 : 0);
      check($sformatf("sq_sync[%0d]", k), bus.phase_sync, (k % 4 == 0 && k > 0) ? 1 : 0);
      tick();
    end
    check("sq_pre_stall_wave", bus.wave, 255);
    check("sq_pre_stall_sync", bus.phase_sync, 1);
    bus.en = 1'b0;
    #1;
    check("stall_sync_low", bus.phase_sync, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("stall_wave[%0d]", c), bus.wave, 255);
      check($sformatf("stall_sync[%0d]", c), bus.phase_sync, 0);
      check($sformatf("stall_valid[%0d]", c), bus.wave_valid, 1);
    end
    bus.en = 1'b1;
    for (int k = 13; k <= 16; k++) begin
      tick();
      check($sformatf("resume_wave[%0d]", k), bus.wave, (k % 4 < 2) ? 255 : 0);
      check($sformatf("resume_sync[%0d]", k), bus.phase_sync, (k % 4 == 0) ? 1 : 0);
    end

    // ---------------- saw, tw=0x0100
    start_sweep(2'd2, 16'h0100);
    for (int k = 0; k <= 256; k++) begin
      check($sformatf("saw_wave[%0d]", k), bus.wave, k % 256);
      check($sformatf("saw_sync[%0d]", k), bus.phase_sync, (k == 256) ? 1 : 0);
      if (k < 256) tick();
    end

    // ---------------- triangle, tw=0x0100
    start_sweep(2'd1, 16'h0100);
    for (int k = 0; k < 256; k++) begin
      exp_v = (k < 128) ? 2 * k : 255 - 2 * (k - 128);
      check($sformatf("tri_wave[%0d]", k), bus.wave, exp_v);
      tick();
    end

    // ---------------- tw_load on the wrap edge (saw, 0x4000 -> 0x1000)
    start_sweep(2'd2, 16'h4000);
    check("twl_wave0", bus.wave, 0);
    tick();
    check("twl_wave1", bus.wave, 64);
    bus.tw_in   = 16'h1000;
    bus.tw_load = 1'b1;
    tick();
    bus.tw_load = 1'b0;
    check("twl_wave2", bus.wave, 128);
    tick();
    check("twl_wave3", bus.wave, 192);
    tick();
    check("twl_wave4", bus.wave, 0);
    check("twl_sync4", bus.phase_sync, 1);
    tick();
    check("twl_wave5", bus.wave, 16);
    check("twl_sync5", bus.phase_sync, 0);
    tick();
    check("twl_wave6", bus.wave, 32);
    tick();
    check("twl_wave7", bus.wave, 48);

    // ---------------- reset mid-sweep, with an ignored tw_load
    reset       = 1'b1;
    bus.tw_in   = 16'h2000;
    bus.tw_load = 1'b1;
    tick();
    check("mid_rst_wave", bus.wave, 127);
    check("mid_rst_valid", bus.wave_valid, 0);
    check("mid_rst_sync", bus.phase_sync, 0);
    reset       = 1'b0;
    bus.tw_load = 1'b0;
    tick();
    check("mid_rst_lat1", bus.wave_valid, 0);
    tick();
    check("mid_rst_lat2", bus.wave_valid, 1);
    check("mid_rst_acc0", bus.wave, 0);
    repeat (3) tick();
    check("mid_rst_tw0", bus.wave, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
